// File: rtl/mini_src_ctrl_seq_if.sv
// Control bundle between the Mini-SRC sequencer and its datapath: IR/run/mem_rdy in, strobes and status out.
// The master modport is the sequencer side; the slave modport is the datapath side.
interface mini_src_ctrl_seq_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic [31:0]      IR;
    logic             mem_rdy;
    logic             PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin;
    logic             Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin;
    logic [15:0]      R0_15_out;
    logic [15:0]      R0_15_in;
    logic [4:0]       opcode;
    logic             busy;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  run, IR, mem_rdy,
        output PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin,
        output Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin,
        output R0_15_out, R0_15_in, opcode, busy, halted, illegal, instr_count
    );

    modport slave (
        output run, IR, mem_rdy,
        input  PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin,
        input  Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin,
        input  R0_15_out, R0_15_in, opcode, busy, halted, illegal, instr_count
    );
endinterface

// File: rtl/mini_src_ctrl_seq.sv
// Hardwired Mini-SRC sequencer: fetch T0-T2, execute T3-T6; strobes are a Moore decode of state plus IR fields.
// T1 stretches while mem_rdy is low and gives up after MEM_WAIT_MAX cycles; run is honoured only at fetch entry.
module mini_src_ctrl_seq #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 16
) (
    input  logic                clock,
    input  logic                clear,
    mini_src_ctrl_seq_if.master ctrl
);
    localparam int WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              illegal_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [4:0]  op;
    logic [15:0] sel_ra, sel_rb, sel_rc;
    logic        is_alu, is_md, is_halt;

    assign op     = ctrl.IR[31:27];
    assign sel_ra = 16'd1 << ctrl.IR[26:23];
    assign sel_rb = 16'd1 << ctrl.IR[22:19];
    assign sel_rc = 16'd1 << ctrl.IR[18:15];

    always_comb begin
        is_alu  = 1'b0;
        is_md   = 1'b0;
        is_halt = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR: is_alu  = 1'b1;
            OP_MUL, OP_DIV:                is_md   = 1'b1;
            OP_HALT:                       is_halt = 1'b1;
            default:                       ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ctrl.run) state <= S_T0;
                end
                S_T0: begin
                    wait_cnt <= '0;
                    state    <= S_T1;
                end
                S_T1: begin
                    // Data arriving on the last permitted cycle still wins over the timeout.
                    if (ctrl.mem_rdy) begin
                        wait_cnt <= '0;
                        state    <= S_T2;
                    end else if (wait_cnt == WAIT_LAST) begin
                        wait_cnt  <= '0;
                        illegal_q <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_T2: state <= S_T3;
                S_T3: begin
                    if (is_halt) begin
                        state <= S_HALT;
                    end else if (is_alu || is_md) begin
                        state <= S_T4;
                    end else begin
                        illegal_q <= 1'b1;
                        state     <= ctrl.run ? S_T0 : S_IDLE;
                    end
                end
                S_T4: state <= S_T5;
                S_T5: begin
                    if (is_md) begin
                        state <= S_T6;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        state <= ctrl.run ? S_T0 : S_IDLE;
                    end
                end
                S_T6: begin
                    cnt_q <= cnt_q + 1'b1;
                    state <= ctrl.run ? S_T0 : S_IDLE;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        ctrl.PCout     = 1'b0;
        ctrl.MARin     = 1'b0;
        ctrl.IncPC     = 1'b0;
        ctrl.PCin      = 1'b0;
        ctrl.Read      = 1'b0;
        ctrl.MDRin     = 1'b0;
        ctrl.MDRout    = 1'b0;
        ctrl.IRin      = 1'b0;
        ctrl.Yin       = 1'b0;
        ctrl.Zlowin    = 1'b0;
        ctrl.Zhighin   = 1'b0;
        ctrl.Zlowout   = 1'b0;
        ctrl.Zhighout  = 1'b0;
        ctrl.LOin      = 1'b0;
        ctrl.HIin      = 1'b0;
        ctrl.R0_15_out = 16'd0;
        ctrl.R0_15_in  = 16'd0;
        ctrl.opcode    = 5'd0;
        case (state)
            S_T0: begin
                ctrl.PCout  = 1'b1;
                ctrl.MARin  = 1'b1;
                ctrl.IncPC  = 1'b1;
                ctrl.Zlowin = 1'b1;
            end
            S_T1: begin
                // PC update happens once per fetch, however long memory stalls.
                ctrl.Read    = 1'b1;
                ctrl.MDRin   = ctrl.mem_rdy;
                ctrl.Zlowout = (wait_cnt == '0);
                ctrl.PCin    = (wait_cnt == '0);
            end
            S_T2: begin
                ctrl.MDRout = 1'b1;
                ctrl.IRin   = 1'b1;
            end
            S_T3: begin
                if (is_alu) begin
                    ctrl.R0_15_out = sel_rb;
                    ctrl.Yin       = 1'b1;
                end else if (is_md) begin
                    ctrl.R0_15_out = sel_ra;
                    ctrl.Yin       = 1'b1;
                end
            end
            S_T4: begin
                ctrl.opcode    = op;
                ctrl.Zlowin    = 1'b1;
                ctrl.Zhighin   = is_md;
                ctrl.R0_15_out = is_md ? sel_rb : sel_rc;
            end
            S_T5: begin
                ctrl.Zlowout  = 1'b1;
                ctrl.LOin     = is_md;
                ctrl.R0_15_in = is_md ? 16'd0 : sel_ra;
            end
            S_T6: begin
                ctrl.Zhighout = 1'b1;
                ctrl.HIin     = 1'b1;
            end
            default: ;
        endcase
    end

    assign ctrl.busy        = (state != S_IDLE) && (state != S_HALT);
    assign ctrl.halted      = (state == S_HALT);
    assign ctrl.illegal     = illegal_q;
    assign ctrl.instr_count = cnt_q;
endmodule

// File: tb/tb_mini_src_ctrl_seq.sv
// Bench for mini_src_ctrl_seq: a small behavioural datapath reacts to the strobes, while per-cycle
// expected strobe sets and per-instruction arithmetic results come from the instruction rules.
module tb_mini_src_ctrl_seq;
    localparam int CNT_W = 8;
    localparam int WMAX  = 15;

    localparam logic [14:0] M_PCOUT    = 15'h0001;
    localparam logic [14:0] M_MARIN    = 15'h0002;
    localparam logic [14:0] M_INCPC    = 15'h0004;
    localparam logic [14:0] M_PCIN     = 15'h0008;
    localparam logic [14:0] M_READ     = 15'h0010;
    localparam logic [14:0] M_MDRIN    = 15'h0020;
    localparam logic [14:0] M_MDROUT   = 15'h0040;
    localparam logic [14:0] M_IRIN     = 15'h0080;
    localparam logic [14:0] M_YIN      = 15'h0100;
    localparam logic [14:0] M_ZLOWIN   = 15'h0200;
    localparam logic [14:0] M_ZHIGHIN  = 15'h0400;
    localparam logic [14:0] M_ZLOWOUT  = 15'h0800;
    localparam logic [14:0] M_ZHIGHOUT = 15'h1000;
    localparam logic [14:0] M_LOIN     = 15'h2000;
    localparam logic [14:0] M_HIIN     = 15'h4000;
    localparam logic [14:0] M_T0       = M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN;

    logic clock = 1'b0;
    logic clear;
    always #5 clock = ~clock;

    mini_src_ctrl_seq_if #(.CNT_W(CNT_W)) ctl_if ();

    mini_src_ctrl_seq #(.MEM_WAIT_MAX(WMAX), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .clear (clear),
        .ctrl  (ctl_if.master)
    );

    int n_chk = 0;
    int n_err = 0;

    // Behavioural datapath state and expectations
    logic [31:0]      rf [16];
    logic [31:0]      pc, mar, mdr, y, zlo, zhi, hi, lo, fetch_word, exp_pc;
    logic             exp_illegal;
    logic [CNT_W-1:0] exp_cnt;
    logic [4:0]       alu_ops [8] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110,
                                      5'b00111, 5'b01000, 5'b01001, 5'b01010};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] strobes();
        return {ctl_if.HIin, ctl_if.LOin, ctl_if.Zhighout, ctl_if.Zlowout, ctl_if.Zhighin,
                ctl_if.Zlowin, ctl_if.Yin, ctl_if.IRin, ctl_if.MDRout, ctl_if.MDRin,
                ctl_if.Read, ctl_if.PCin, ctl_if.IncPC, ctl_if.MARin, ctl_if.PCout};
    endfunction

    function automatic logic [15:0] oh(input logic [3:0] i);
        logic [15:0] v;
        v = 16'd1 << i;
        return v;
    endfunction

    function automatic logic [63:0] alu(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (o)
            5'b00011: return {32'd0, a + b};
            5'b00100: return {32'd0, a - b};
            5'b00101: return {32'd0, a >> sh};
            5'b00110: return {32'd0, a << sh};
            5'b00111: return {32'd0, (a >> sh) | (a << (32 - sh))};
            5'b01000: return {32'd0, (a << sh) | (a >> (32 - sh))};
            5'b01001: return {32'd0, a & b};
            5'b01010: return {32'd0, a | b};
            5'b01111: return {32'd0, a} * {32'd0, b};
            5'b10000: return (b == 0) ? 64'd0 : {a % b, a / b};
            default:  return 64'd0;
        endcase
    endfunction

    // Datapath reaction to the strobes seen this cycle; all updates use pre-edge values.
    task automatic dp_step();
        logic [14:0] s;
        logic [15:0] so, si;
        logic [4:0]  opc;
        logic [31:0] b;
        logic [63:0] r;
        int nd;
        s = strobes(); so = ctl_if.R0_15_out; si = ctl_if.R0_15_in; opc = ctl_if.opcode;
        b = 32'd0; nd = 0;
        if (s & M_PCOUT)    begin b = pc;  nd++; end
        if (s & M_MDROUT)   begin b = mdr; nd++; end
        if (s & M_ZLOWOUT)  begin b = zlo; nd++; end
        if (s & M_ZHIGHOUT) begin b = zhi; nd++; end
        for (int k = 0; k < 16; k++) if (so[k]) begin b = rf[k]; nd++; end
        chk("bus_drivers", 32'(nd > 1), 32'd0);
        if (s & (M_ZLOWIN | M_ZHIGHIN)) begin
            if (s & M_INCPC) zlo = b + 32'd1;
            else begin
                r = alu(opc, y, b);
                if (s & M_ZLOWIN)  zlo = r[31:0];
                if (s & M_ZHIGHIN) zhi = r[63:32];
            end
        end
        if (s & M_MARIN) mar = b;
        if (s & M_PCIN)  pc = b;
        if ((s & M_READ) && (s & M_MDRIN)) mdr = fetch_word;
        if (s & M_IRIN)  ctl_if.IR = b;
        if (s & M_YIN)   y = b;
        if (s & M_LOIN)  lo = b;
        if (s & M_HIIN)  hi = b;
        for (int k = 0; k < 16; k++) if (si[k]) rf[k] = b;
    endtask

    task automatic cyc(input logic rdy, input logic [14:0] s, input logic [4:0] opc, input logic bsy,
                       input logic hlt, input logic [15:0] eo, input logic [15:0] ei, input string tag);
        ctl_if.mem_rdy = rdy;
        #1;
        chk({tag, "_ctl"}, {9'd0, ctl_if.illegal, ctl_if.busy, ctl_if.halted, ctl_if.opcode, strobes()},
            {9'd0, exp_illegal, bsy, hlt, opc, s});
        chk({tag, "_sel"}, {ctl_if.R0_15_out, ctl_if.R0_15_in}, {eo, ei});
        dp_step();
        @(negedge clock);
    endtask

    task automatic post_clear();
        clear = 1'b0;
        exp_illegal = 1'b0;
        exp_cnt = '0;
        cyc(1'b0, 15'd0, 5'd0, 1'b0, 1'b0, 16'd0, 16'd0, "rst");
        chk("rst_cnt", 32'(ctl_if.instr_count), 32'd0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clock);
        post_clear();
    endtask

    // Runs one instruction starting in T0. clr_at==4 asserts clear during T4 and stops there.
    task automatic exec_instr(input logic [31:0] w, input int dly, input bit drop_run, input int clr_at);
        logic [4:0]  o;
        logic [3:0]  ra, rb, rc;
        logic [31:0] va, vb, vc;
        logic [63:0] r;
        bit alu_op, md_op;
        o = w[31:27]; ra = w[26:23]; rb = w[22:19]; rc = w[18:15];
        va = rf[ra]; vb = rf[rb]; vc = rf[rc];
        alu_op = (o inside {5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001, 5'b01010});
        md_op  = (o == 5'b01111) || (o == 5'b10000);
        fetch_word = w;
        cyc(1'b0, M_T0, 5'd0, 1'b1, 1'b0, 16'd0, 16'd0, "t0");
        for (int k = 0; k <= dly; k++)
            cyc(k == dly, M_READ | ((k == 0) ? (M_ZLOWOUT | M_PCIN) : 15'd0) | ((k == dly) ? M_MDRIN : 15'd0),
                5'd0, 1'b1, 1'b0, 16'd0, 16'd0, "t1");
        cyc(1'b0, M_MDROUT | M_IRIN, 5'd0, 1'b1, 1'b0, 16'd0, 16'd0, "t2");
        exp_pc = exp_pc + 32'd1;
        chk("pc", pc, exp_pc);
        if (drop_run) ctl_if.run = 1'b0;
        if (!alu_op && !md_op) begin
            cyc(1'b0, 15'd0, 5'd0, 1'b1, 1'b0, 16'd0, 16'd0, "t3_noop");
            if (o != 5'b11011) exp_illegal = 1'b1;
            chk("cnt_unretired", 32'(ctl_if.instr_count), 32'(exp_cnt));
            return;
        end
        cyc(1'b0, M_YIN, 5'd0, 1'b1, 1'b0, oh(alu_op ? rb : ra), 16'd0, "t3");
        if (clr_at == 4) clear = 1'b1;
        cyc(1'b0, M_ZLOWIN | (md_op ? M_ZHIGHIN : 15'd0), o, 1'b1, 1'b0, oh(md_op ? rb : rc), 16'd0, "t4");
        if (clr_at == 4) return;
        if (alu_op) begin
            cyc(1'b0, M_ZLOWOUT, 5'd0, 1'b1, 1'b0, 16'd0, oh(ra), "t5");
            r = alu(o, vb, vc);
            chk("alu_result", rf[ra], r[31:0]);
        end else begin
            cyc(1'b0, M_ZLOWOUT | M_LOIN, 5'd0, 1'b1, 1'b0, 16'd0, 16'd0, "t5");
            cyc(1'b0, M_ZHIGHOUT | M_HIIN, 5'd0, 1'b1, 1'b0, 16'd0, 16'd0, "t6");
            r = alu(o, va, vb);
            chk("lo_result", lo, r[31:0]);
            chk("hi_result", hi, r[63:32]);
        end
        exp_cnt = exp_cnt + 1'b1;
        chk("cnt", 32'(ctl_if.instr_count), 32'(exp_cnt));
    endtask

    task automatic idle_restart();
        cyc(1'b0, 15'd0, 5'd0, 1'b0, 1'b0, 16'd0, 16'd0, "idle_hold");
        ctl_if.run = 1'b1;
        cyc(1'b0, 15'd0, 5'd0, 1'b0, 1'b0, 16'd0, 16'd0, "idle_go");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clear = 1'b1;
        ctl_if.run = 1'b1;
        ctl_if.mem_rdy = 1'b0;
        ctl_if.IR = 32'd0;
        for (int k = 0; k < 16; k++) rf[k] = $urandom;
        pc = 32'd0; exp_pc = 32'd0; mar = 0; mdr = 0; y = 0; zlo = 0; zhi = 0; hi = 0; lo = 0;
        fetch_word = 32'd0; exp_illegal = 1'b0; exp_cnt = '0;
        repeat (3) @(negedge clock);
        post_clear();

        // shr R1,R2,R3 with zero-wait memory
        rf[2] = 32'h19; rf[3] = 32'h3;
        exec_instr(32'h28918000, 0, 1'b0, -1);
        chk("shr_r1", rf[1], 32'h3);
        chk("shr_cnt", 32'(ctl_if.instr_count), 32'd1);

        // mul R4,R5
        rf[4] = 32'h12345; rf[5] = 32'h6789A;
        exec_instr(32'h7A280000, 0, 1'b0, -1);

        // memory stall of 3 cycles
        exec_instr({5'b00011, 4'd6, 4'd7, 4'd8, 15'd0}, 3, 1'b0, -1);

        // memory never answers
        cyc(1'b0, M_T0, 5'd0, 1'b1, 1'b0, 16'd0, 16'd0, "to_t0");
        for (int k = 0; k < WMAX; k++)
            cyc(1'b0, M_READ | ((k == 0) ? (M_ZLOWOUT | M_PCIN) : 15'd0), 5'd0, 1'b1, 1'b0, 16'd0, 16'd0, "to_t1");
        exp_pc = exp_pc + 32'd1;
        exp_illegal = 1'b1;
        cyc(1'b0, 15'd0, 5'd0, 1'b0, 1'b0, 16'd0, 16'd0, "to_idle");
        exec_instr({5'b01001, 4'd9, 4'd10, 4'd11, 15'd0}, 1, 1'b0, -1);
        do_clear();

        // undefined opcode, then straight back to fetch
        exec_instr(32'hF8000000, 0, 1'b0, -1);
        exec_instr({5'b00100, 4'd2, 4'd3, 4'd4, 15'd0}, 0, 1'b0, -1);
        do_clear();

        // halt ignores run until clear
        exec_instr(32'hD8000000, 0, 1'b0, -1);
        for (int k = 0; k < 4; k++) cyc(1'b0, 15'd0, 5'd0, 1'b0, 1'b1, 16'd0, 16'd0, "halt");
        do_clear();

        // clear in the middle of T4
        exec_instr({5'b00110, 4'd1, 4'd2, 4'd3, 15'd0}, 0, 1'b0, 4);
        post_clear();

        // run dropped during T3 of an ALU op and of a mul/div op
        exec_instr({5'b01010, 4'd3, 4'd4, 4'd5, 15'd0}, 1, 1'b1, -1);
        idle_restart();
        exec_instr({5'b10000, 4'd6, 4'd7, 4'd0, 15'd0}, 0, 1'b1, -1);
        idle_restart();

        // randomized mix; enough retirements to wrap the counter
        for (int i = 0; i < 400; i++) begin
            logic [4:0] o;
            logic [31:0] w;
            int dly;
            bit drop;
            case ($urandom_range(0, 19))
                0: begin
                    do o = 5'($urandom_range(0, 31));
                    while (o inside {5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                                     5'b01001, 5'b01010, 5'b01111, 5'b10000, 5'b11011});
                end
                1: o = 5'b01111;
                2: o = 5'b10000;
                default: o = alu_ops[$urandom_range(0, 7)];
            endcase
            w = {o, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 15'($urandom)};
            dly = $urandom_range(0, 4);
            drop = ($urandom_range(0, 6) == 0);
            exec_instr(w, dly, drop, -1);
            if (drop) idle_restart();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
